// File: rtl/soc_bus_arb.sv
// Multi-master / multi-slave bus arbiter and address decoder for the picorv32 SoC.
// One transfer at a time: IDLE grants, ACCESS drives the slave for 1+wait cycles, DONE pulses ready.
module soc_bus_arb #(
  parameter int                 N_MST    = 2,
  parameter int                 N_SLV    = 4,
  parameter int                 AW       = 32,
  parameter int                 DW       = 32,
  parameter int                 SEL_LO   = 16,
  parameter int                 SEL_W    = 2,
  parameter logic [4*N_SLV-1:0] WAIT_VEC = '0,
  parameter int                 RR       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_MST-1:0]      m_valid,
  input  logic [N_MST*AW-1:0]   m_adr,
  input  logic [N_MST*DW-1:0]   m_wdata,
  input  logic [N_MST*DW/8-1:0] m_wstrb,
  output logic [N_MST-1:0]      m_ready,
  output logic [N_MST-1:0]      m_err,
  output logic [DW-1:0]         m_rdata,
  output logic [N_SLV-1:0]      s_sel,
  output logic [AW-1:0]         s_adr,
  output logic [DW-1:0]         s_wdata,
  output logic [DW/8-1:0]       s_wstrb,
  input  logic [N_SLV*DW-1:0]   s_rdata
);

  localparam int GW = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state_q, state_d;
  logic [GW-1:0]      gnt_q, gnt_d;
  logic [GW-1:0]      ptr_q, ptr_d;
  logic [SEL_W-1:0]   slv_q, slv_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [DW-1:0]      rdata_d;

  logic [GW-1:0]      req_gnt;
  logic [SEL_W-1:0]   req_slv;
  logic               req_mapped;
  logic [3:0]         req_wait;
  logic [DW-1:0]      slv_rdata;
  logic [N_SLV-1:0]   slv_onehot;
  logic [AW-1:0]      gnt_adr;
  logic [DW-1:0]      gnt_wdata;
  logic [SW-1:0]      gnt_wstrb;

  // Descending scan so the last hit is the first requester in priority order.
  function automatic logic [GW-1:0] pick_grant(input logic [N_MST-1:0] req,
                                               input logic [GW-1:0]    ptr);
    logic [GW-1:0] g;
    int            idx;
    g = '0;
    if (RR == 0) begin
      for (int i = N_MST - 1; i >= 0; i--)
        if (req[i]) g = GW'(i);
    end else begin
      for (int i = N_MST; i >= 1; i--) begin
        idx = (int'(ptr) + i) % N_MST;
        if (req[idx]) g = GW'(idx);
      end
    end
    return g;
  endfunction

  assign req_gnt = pick_grant(m_valid, ptr_q);

  always_comb begin
    req_slv = '0;
    for (int i = 0; i < N_MST; i++)
      if (req_gnt == GW'(i)) req_slv = m_adr[i*AW+SEL_LO +: SEL_W];
  end

  always_comb begin
    req_mapped = 1'b0;
    req_wait   = '0;
    for (int j = 0; j < N_SLV; j++)
      if (req_slv == SEL_W'(j)) begin
        req_mapped = 1'b1;
        req_wait   = WAIT_VEC[4*j +: 4];
      end
  end

  always_comb begin
    slv_rdata  = '0;
    slv_onehot = '0;
    for (int j = 0; j < N_SLV; j++)
      if (slv_q == SEL_W'(j)) begin
        slv_rdata     = s_rdata[j*DW +: DW];
        slv_onehot[j] = 1'b1;
      end
  end

  always_comb begin
    gnt_adr   = '0;
    gnt_wdata = '0;
    gnt_wstrb = '0;
    for (int i = 0; i < N_MST; i++)
      if (gnt_q == GW'(i)) begin
        gnt_adr   = m_adr[i*AW +: AW];
        gnt_wdata = m_wdata[i*DW +: DW];
        gnt_wstrb = m_wstrb[i*SW +: SW];
      end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= GW'(N_MST - 1);
      slv_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      m_rdata <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      slv_q   <= slv_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      m_rdata <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    slv_d   = slv_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = m_rdata;
    case (state_q)
      IDLE: begin
        if (|m_valid) begin
          gnt_d = req_gnt;
          slv_d = req_slv;
          if (req_mapped) begin
            cnt_d   = req_wait;
            err_d   = 1'b0;
            state_d = ACCESS;
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = DONE;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = 4'(cnt_q - 4'd1);
        end else begin
          rdata_d = slv_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        ptr_d   = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address and data are always routed from the grant; only select and strobes are phase-gated.
  always_comb begin
    m_ready = '0;
    m_err   = '0;
    s_sel   = '0;
    s_wstrb = '0;
    s_adr   = gnt_adr;
    s_wdata = gnt_wdata;
    case (state_q)
      ACCESS: begin
        s_sel   = slv_onehot;
        s_wstrb = gnt_wstrb;
      end
      DONE: begin
        m_ready[gnt_q] = 1'b1;
        m_err[gnt_q]   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_soc_bus_arb.sv
// Directed bench for soc_bus_arb: a fixed-priority and a round-robin instance share stimulus.
// Slave windows: 0 (wait 0), 1 (wait 1), 2 (wait 3); window 3 is unmapped.
module tb_soc_bus_arb;

  logic        clk;
  logic        reset;
  logic [1:0]  m_valid;
  logic [63:0] m_adr;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic [95:0] s_rdata;

  logic [1:0]  fp_ready, fp_err, rr_ready, rr_err;
  logic [31:0] fp_rdata, rr_rdata, fp_adr, rr_adr, fp_wdata, rr_wdata;
  logic [2:0]  fp_sel, rr_sel;
  logic [3:0]  fp_wstrb, rr_wstrb;

  int vecs = 0;
  int errs = 0;

  soc_bus_arb #(.N_MST(2), .N_SLV(3), .AW(32), .DW(32), .SEL_LO(16), .SEL_W(2),
                .WAIT_VEC(12'h310), .RR(0)) dut_fp (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_adr(m_adr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_ready(fp_ready), .m_err(fp_err), .m_rdata(fp_rdata),
    .s_sel(fp_sel), .s_adr(fp_adr), .s_wdata(fp_wdata), .s_wstrb(fp_wstrb),
    .s_rdata(s_rdata)
  );

  soc_bus_arb #(.N_MST(2), .N_SLV(3), .AW(32), .DW(32), .SEL_LO(16), .SEL_W(2),
                .WAIT_VEC(12'h310), .RR(1)) dut_rr (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_adr(m_adr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_ready(rr_ready), .m_err(rr_err), .m_rdata(rr_rdata),
    .s_sel(rr_sel), .s_adr(rr_adr), .s_wdata(rr_wdata), .s_wstrb(rr_wstrb),
    .s_rdata(s_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vecs);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    vecs++;
    if ({fp_ready, rr_ready, fp_err, rr_err} !== 8'h00) begin
      errs++; $display("FAIL rst_ready_err: got %b want 00000000", {fp_ready, rr_ready, fp_err, rr_err});
    end
    vecs++;
    if ({fp_rdata, rr_rdata} !== 64'h0) begin
      errs++; $display("FAIL rst_rdata: got %h/%h want 0", fp_rdata, rr_rdata);
    end
    vecs++;
    if ({fp_sel, rr_sel, fp_wstrb, rr_wstrb} !== 14'h0) begin
      errs++; $display("FAIL rst_sel_wstrb: got %b %b %h %h want 0", fp_sel, rr_sel, fp_wstrb, rr_wstrb);
    end
    reset = 1'b0;
    @(negedge clk);
    vecs++;
    if ({fp_ready, rr_ready, fp_sel, rr_sel} !== 10'h0) begin
      errs++; $display("FAIL rst_idle_quiet: got %b %b %b %b want 0", fp_ready, rr_ready, fp_sel, rr_sel);
    end
  endtask

  task automatic test_read_slave0();
    m_valid = 2'b01;
    m_adr[31:0] = 32'h0000_0010;
    m_wstrb = 8'h00;
    #1;
    vecs++;
    if ({fp_sel, rr_sel} !== 6'b000000) begin
      errs++; $display("FAIL rd0_c0_sel: got %b/%b want 000", fp_sel, rr_sel);
    end
    @(negedge clk);
    vecs++;
    if ({fp_sel, rr_sel} !== {2{3'b001}}) begin
      errs++; $display("FAIL rd0_c1_sel: got %b/%b want 001", fp_sel, rr_sel);
    end
    vecs++;
    if ({fp_adr, rr_adr} !== {2{32'h0000_0010}}) begin
      errs++; $display("FAIL rd0_c1_adr: got %h/%h want 00000010", fp_adr, rr_adr);
    end
    vecs++;
    if ({fp_ready, rr_ready} !== 4'b0000) begin
      errs++; $display("FAIL rd0_c1_ready: got %b/%b want 00", fp_ready, rr_ready);
    end
    @(negedge clk);
    vecs++;
    if ({fp_ready, rr_ready, fp_err, rr_err} !== 8'b0101_0000) begin
      errs++; $display("FAIL rd0_c2_ready_err: got %b/%b %b/%b want 01/01 00/00", fp_ready, rr_ready, fp_err, rr_err);
    end
    vecs++;
    if ({fp_rdata, rr_rdata} !== {2{32'hDEAD_BEEF}}) begin
      errs++; $display("FAIL rd0_c2_rdata: got %h/%h want deadbeef", fp_rdata, rr_rdata);
    end
    m_valid = 2'b00;
    @(negedge clk);
    vecs++;
    if ({fp_ready, rr_ready} !== 4'b0000) begin
      errs++; $display("FAIL rd0_c3_ready: got %b/%b want 00", fp_ready, rr_ready);
    end
  endtask

  task automatic test_read_slave1();
    m_valid = 2'b01;
    m_adr[31:0] = 32'h0001_0008;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      vecs++;
      if ({fp_sel, rr_sel, fp_ready, rr_ready} !== {3'b010, 3'b010, 4'b0000}) begin
        errs++; $display("FAIL rd1_c%0d: sel %b/%b ready %b/%b want 010 00", c, fp_sel, rr_sel, fp_ready, rr_ready);
      end
    end
    @(negedge clk);
    vecs++;
    if ({fp_ready, rr_ready} !== 4'b0101) begin
      errs++; $display("FAIL rd1_c3_ready: got %b/%b want 01", fp_ready, rr_ready);
    end
    vecs++;
    if ({fp_rdata, rr_rdata} !== {2{32'h1111_1111}}) begin
      errs++; $display("FAIL rd1_c3_rdata: got %h/%h want 11111111", fp_rdata, rr_rdata);
    end
    m_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_write_wait();
    m_valid = 2'b10;
    m_adr[63:32] = 32'h0002_0004;
    m_wdata[63:32] = 32'h1234_5678;
    m_wstrb[7:4] = 4'hF;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      vecs++;
      if ({fp_sel, rr_sel, fp_wstrb, rr_wstrb, fp_ready, rr_ready} !== {3'b100, 3'b100, 4'hF, 4'hF, 4'b0000}) begin
        errs++; $display("FAIL wr_c%0d: sel %b/%b wstrb %h/%h ready %b/%b want 100 f 00", c, fp_sel, rr_sel, fp_wstrb, rr_wstrb, fp_ready, rr_ready);
      end
      vecs++;
      if ({fp_wdata, rr_wdata, fp_adr} !== {32'h1234_5678, 32'h1234_5678, 32'h0002_0004}) begin
        errs++; $display("FAIL wr_c%0d_data: wdata %h/%h adr %h want 12345678 00020004", c, fp_wdata, rr_wdata, fp_adr);
      end
    end
    @(negedge clk);
    vecs++;
    if ({fp_ready, rr_ready, fp_err, rr_err} !== 8'b1010_0000) begin
      errs++; $display("FAIL wr_c5_ready_err: got %b/%b %b/%b want 10/10 00/00", fp_ready, rr_ready, fp_err, rr_err);
    end
    vecs++;
    if ({fp_sel, rr_sel, fp_wstrb, rr_wstrb} !== 14'h0) begin
      errs++; $display("FAIL wr_c5_quiet: sel %b/%b wstrb %h/%h want 0", fp_sel, rr_sel, fp_wstrb, rr_wstrb);
    end
    m_valid = 2'b00;
    m_wstrb = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [1:0] exp_fp, exp_rr;
    logic [2:0] exp_sel;
    m_valid = 2'b11;
    m_adr = {32'h0000_0020, 32'h0000_0020};
    m_wstrb = 8'h00;
    for (int c = 0; c < 12; c++) begin
      if (c == 0) #1;
      else @(negedge clk);
      exp_fp  = (c % 3 == 2) ? 2'b01 : 2'b00;
      exp_rr  = (c % 3 != 2) ? 2'b00 : (((c / 3) % 2 == 0) ? 2'b01 : 2'b10);
      exp_sel = (c % 3 == 1) ? 3'b001 : 3'b000;
      vecs++;
      if (fp_ready !== exp_fp) begin
        errs++; $display("FAIL arb_fp_c%0d: ready %b want %b", c, fp_ready, exp_fp);
      end
      vecs++;
      if (rr_ready !== exp_rr) begin
        errs++; $display("FAIL arb_rr_c%0d: ready %b want %b", c, rr_ready, exp_rr);
      end
      vecs++;
      if ({fp_sel, rr_sel} !== {exp_sel, exp_sel}) begin
        errs++; $display("FAIL arb_sel_c%0d: sel %b/%b want %b", c, fp_sel, rr_sel, exp_sel);
      end
    end
    m_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_unmapped();
    m_valid = 2'b01;
    m_adr[31:0] = 32'h0003_0000;
    #1;
    vecs++;
    if ({fp_ready, rr_ready, fp_sel, rr_sel} !== 10'h0) begin
      errs++; $display("FAIL um_c0: ready %b/%b sel %b/%b want 0", fp_ready, rr_ready, fp_sel, rr_sel);
    end
    @(negedge clk);
    vecs++;
    if ({fp_ready, rr_ready, fp_err, rr_err} !== 8'b0101_0101) begin
      errs++; $display("FAIL um_c1_ready_err: got %b/%b %b/%b want 01/01 01/01", fp_ready, rr_ready, fp_err, rr_err);
    end
    vecs++;
    if ({fp_rdata, rr_rdata} !== 64'h0) begin
      errs++; $display("FAIL um_c1_rdata: got %h/%h want 0", fp_rdata, rr_rdata);
    end
    vecs++;
    if ({fp_sel, rr_sel} !== 6'b0) begin
      errs++; $display("FAIL um_c1_sel: got %b/%b want 000", fp_sel, rr_sel);
    end
    m_valid = 2'b00;
    @(negedge clk);
    vecs++;
    if ({fp_ready, rr_ready, fp_err, rr_err} !== 8'h00) begin
      errs++; $display("FAIL um_c2_quiet: got %b/%b %b/%b want 0", fp_ready, rr_ready, fp_err, rr_err);
    end
  endtask

  task automatic test_reset_mid();
    m_valid = 2'b01;
    m_adr[31:0] = 32'h0002_0000;
    m_wdata[31:0] = 32'hCAFE_F00D;
    m_wstrb[3:0] = 4'hF;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      vecs++;
      if ({fp_sel, rr_sel, fp_wstrb, rr_wstrb} !== {3'b100, 3'b100, 4'hF, 4'hF}) begin
        errs++; $display("FAIL rm_c%0d: sel %b/%b wstrb %h/%h want 100 f", c, fp_sel, rr_sel, fp_wstrb, rr_wstrb);
      end
    end
    reset = 1'b1;
    #1;
    vecs++;
    if ({fp_sel, rr_sel, fp_wstrb, rr_wstrb, fp_ready, rr_ready} !== 18'h0) begin
      errs++; $display("FAIL rm_async: sel %b/%b wstrb %h/%h ready %b/%b want 0", fp_sel, rr_sel, fp_wstrb, rr_wstrb, fp_ready, rr_ready);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vecs++;
      if ({fp_ready, rr_ready} !== 4'b0000) begin
        errs++; $display("FAIL rm_hold_%0d: ready %b/%b want 00", c, fp_ready, rr_ready);
      end
    end
    m_valid = 2'b11;
    m_adr = {32'h0000_0020, 32'h0000_0020};
    m_wstrb = 8'h00;
    reset = 1'b0;
    #1;
    vecs++;
    if ({fp_ready, rr_ready} !== 4'b0000) begin
      errs++; $display("FAIL rm_rel_c0: ready %b/%b want 00", fp_ready, rr_ready);
    end
    @(negedge clk);
    vecs++;
    if ({fp_sel, rr_sel} !== {2{3'b001}}) begin
      errs++; $display("FAIL rm_rel_c1_sel: got %b/%b want 001", fp_sel, rr_sel);
    end
    @(negedge clk);
    vecs++;
    if (rr_ready !== 2'b01) begin
      errs++; $display("FAIL rm_rr_first: ready %b want 01", rr_ready);
    end
    vecs++;
    if (fp_ready !== 2'b01) begin
      errs++; $display("FAIL rm_fp_first: ready %b want 01", fp_ready);
    end
    m_valid = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    m_valid = 2'b00;
    m_adr   = '0;
    m_wdata = '0;
    m_wstrb = '0;
    s_rdata = {32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
    test_reset();
    test_read_slave0();
    test_read_slave1();
    test_write_wait();
    test_contention();
    test_unmapped();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/soc_bus_arb.md
Name: soc_bus_arb

Overview:
Parametrised multi-master, multi-slave bus arbiter and decoder for the picorv32 SoC. It replaces the hard-wired debug/CPU bus mux and the fixed one-cycle mem_rdy generator. It supports N masters with fixed-priority or round-robin arbitration, and N slave windows decoded from address bits. Each slave has its own programmable wait-state count, and unmapped windows return an error response. It sits between the masters (CPU, debug unit, future DMA) and the RAM/ROM/MMIO blocks.

Parameters:
N_MST, 2, number of masters; index 0 is the highest fixed priority.
N_SLV, 4, number of slave windows.
AW, 32, address width.
DW, 32, data width (multiple of 8).
SEL_LO, 16, low bit of the slave index field in the address.
SEL_W, 2, width of the slave index field (adr[SEL_LO+SEL_W-1:SEL_LO]).
WAIT_VEC, 0, packed 4 bits per slave giving the wait cycles for slave k in bits [4k+3:4k].
RR, 0, arbitration mode: 0 = fixed priority, 1 = round-robin.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
m_valid  in  N_MST  per-master request
m_adr  in  N_MST*AW  packed master addresses; master i uses [i*AW +: AW]
m_wdata  in  N_MST*DW  packed write data
m_wstrb  in  N_MST*DW/8  packed byte write strobes; all zero means read
m_ready  out  N_MST  one-cycle completion pulse to the granted master
m_err  out  N_MST  coincident with m_ready when the access hit an unmapped window
m_rdata  out  DW  registered read data, shared by all masters
s_sel  out  N_SLV  one-hot slave chip select
s_adr  out  AW  address of the granted master
s_wdata  out  DW  write data of the granted master
s_wstrb  out  DW/8  strobes of the granted master, gated by the access phase
s_rdata  in  N_SLV*DW  packed slave read data

Behaviour:
- States are IDLE, ACCESS, DONE.
- Reset (async, any state):
  - state goes to IDLE; grant and counter go to 0.
  - m_ready, m_err, m_rdata, s_sel and s_wstrb go to 0.
  - The round-robin pointer goes to N_MST-1, so master 0 wins first.
- IDLE, any m_valid set:
  - The grant index g is latched: lowest set index when RR=0; first set index after the pointer, wrapping, when RR=1.
  - The slave index k is latched from m_adr[g].
  - If k < N_SLV, the counter loads WAIT_VEC[k] and state goes to ACCESS.
  - If k >= N_SLV, state goes to DONE with the error flag set and m_rdata loaded with 0.
- IDLE, no request: state stays IDLE and all outputs are quiet.
- ACCESS:
  - s_sel[k]=1; s_adr, s_wdata and s_wstrb follow master g combinationally.
  - Counter > 0: decrement each cycle.
  - Counter = 0: register s_rdata[k] into m_rdata and go to DONE.
- DONE:
  - s_sel and s_wstrb are 0; m_ready[g]=1 and m_err[g]=error flag for exactly one cycle.
  - The RR pointer updates to g.
  - Next state is IDLE.
- Latency: the first cycle valid is seen in IDLE is cycle 0; m_ready is high in cycle 2+WAIT_VEC[k]; an unmapped access has m_ready in cycle 1.
- The minimum gap between grants is one IDLE cycle, which guarantees a master has dropped valid after its ready.
- Outside ACCESS, s_sel and s_wstrb are all zero. s_adr and s_wdata may show master g but carry no meaning.
- m_rdata holds its value until the next DONE. On a write, m_rdata is still loaded from the slave and its value is don't-care.
- A master that drops m_valid mid-access does not abort the transfer. It completes, and the ready pulse is issued and ignored.
- Requests from other masters during an access wait; there is no preemption.
- A grant always goes only to a master with m_valid high in the IDLE cycle.
- A write held over W+1 ACCESS cycles repeats identical strobes and data; slaves must tolerate this idempotent rewrite.

Test Plan:
- WAIT_VEC=0, master 0 reads adr 0x00010 from slave 0 with s_rdata0=0xDEADBEEF -> s_sel=0001 in cycle 1, m_ready[0] in cycle 2, m_rdata=0xDEADBEEF, m_err=0.
- WAIT_VEC for slave 2 = 3, master 1 writes 0x20004 with wstrb 0xF and data 0x12345678 -> s_sel=0100 with s_wstrb=0xF for 4 cycles, m_ready[1] in cycle 5.
- RR=0, both masters request slave 0 every cycle -> master 0 is granted every transaction and master 1 starves; ready pulses only on m_ready[0].
- RR=1, same stimulus -> grants alternate 0,1,0,1 with one IDLE cycle between DONE and the next ACCESS.
- SEL_W=2, N_SLV=3, access to 0x30000 -> no s_sel asserted, m_ready and m_err high in cycle 1, m_rdata=0.
- Assert reset during ACCESS with wait 3 -> s_sel, s_wstrb and m_ready go to 0 immediately with no ready pulse; after release, master 0 wins first under RR=1.
